ptpv2_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the ptpv2 core's shared 32-bit bus2ip register interface, which is decoded by the rtc and timestamp units. Master 0 is the host CPU bridge; master 1 is an on-chip servo or timestamp-readout engine. The arbiter serialises single-word transactions with round-robin fairness, drives one-cycle rd/wr chip-enables, and captures read data after a fixed latency.

---
 rtl/ptpv2_bus_arbiter_pkg.sv | 19 +
 rtl/ptpv2_bus_arbiter_rr_arb2.sv | 24 ++
 rtl/ptpv2_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ptpv2_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptpv2_bus_arbiter_pkg.sv
// Shared types and constants for the ptpv2 bus2ip arbiter: FSM state
// encoding, read-latency bound and grant helpers.
package ptpv2_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = 3;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ptpv2_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: ties go to the master not served
// last; mask_i restricts the eligible set (used for lock parking).
module ptpv2_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] mask_i,
  output logic       valid_o,
  output logic       idx_o
);

  logic [1:0] elig;

  always_comb begin
    elig    = req_i & mask_i;
    valid_o = |elig;
    idx_o   = 1'b0;
    if (elig == 2'b11) begin
      idx_o = ~last_i;
    end else if (elig[1]) begin
      idx_o = 1'b1;
    end
  end

endmodule

// File: rtl/ptpv2_bus_arbiter.sv
// Two-master arbiter/sequencer for the ptpv2 bus2ip register interface.
// Optional master lock parking is enabled by defining PTPV2_ARB_LOCK_EN.
module ptpv2_bus_arbiter
  import ptpv2_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                bus2ip_clk,
  input  logic                bus2ip_rst,
  input  logic [1:0]          req_i,
  input  logic [1:0]          wr_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [63:0]         wdata_i,
  input  logic [1:0]          lock_i,
  output logic [1:0]          ack_o,
  output logic [63:0]         rdata_o,
  output logic [31:0]         bus2ip_addr_o,
  output logic [31:0]         bus2ip_data_o,
  output logic                bus2ip_rd_ce_o,
  output logic                bus2ip_wr_ce_o,
  input  logic [31:0]         ip2bus_data_i,
  output logic                busy_o
);

  localparam int unsigned RD_LAT_EFF = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                       ((RD_LAT == 0) ? 1 : RD_LAT);
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT_EFF);

  arb_state_t       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             wr_q, wr_d;
  logic             last_q, last_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ack_q, ack_d;
  logic             rd_ce_q, rd_ce_d;
  logic             wr_ce_q, wr_ce_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             busy_q, busy_d;

  logic             arb_valid;
  logic             arb_idx;
  logic [1:0]       lock_mask;
  logic [ADDR_W-1:0] sel_addr;

`ifdef PTPV2_ARB_LOCK_EN
  logic lock_q, lock_d;

  // Parked on gnt_q while its lock stays high; a low lock seen in IDLE
  // releases the mask in the same cycle so normal arbitration resumes at once.
  assign lock_mask = (lock_q && lock_i[gnt_q]) ? onehot2(gnt_q) : 2'b11;

  always_comb begin
    lock_d = lock_q;
    if (state_q == DONE) begin
      lock_d = lock_i[gnt_q];
    end else if (state_q == IDLE && !lock_i[gnt_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign lock_mask   = 2'b11;
`endif

  ptpv2_rr_arb2 u_rr (
    .req_i   (req_i),
    .last_i  (last_q),
    .mask_i  (lock_mask),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  assign sel_addr = arb_idx ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    rd_ce_d = 1'b0;
    wr_ce_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          wr_d    = wr_i[arb_idx];
          addr_d  = 32'(sel_addr);
          wdata_d = arb_idx ? wdata_i[63:32] : wdata_i[31:0];
          wr_ce_d = wr_i[arb_idx];
          rd_ce_d = ~wr_i[arb_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          ack_d   = onehot2(gnt_q);
          state_d = DONE;
        end else begin
          cnt_d   = 3'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == RD_LAT_C) begin
          if (gnt_q) begin
            rdata_d[63:32] = ip2bus_data_i;
          end else begin
            rdata_d[31:0] = ip2bus_data_i;
          end
          ack_d   = onehot2(gnt_q);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        addr_d  = '0;
        wdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rd_ce_q <= 1'b0;
      wr_ce_q <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rd_ce_q <= rd_ce_d;
      wr_ce_q <= wr_ce_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_o          = ack_q;
  assign rdata_o        = rdata_q;
  assign bus2ip_addr_o  = addr_q;
  assign bus2ip_data_o  = wdata_q;
  assign bus2ip_rd_ce_o = rd_ce_q;
  assign bus2ip_wr_ce_o = wr_ce_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_ptpv2_bus_arbiter.sv
// Self-checking bench for ptpv2_bus_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_ptpv2_bus_arbiter;

  localparam int unsigned RD_LAT = 3;
  localparam int unsigned ADDR_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req, wr, lock;
  logic [2*ADDR_W-1:0] addr;
  logic [63:0]         wdata;
  logic [1:0]          ack;
  logic [63:0]         rdata;
  logic [31:0]         baddr, bdata, ip_data;
  logic                rd_ce, wr_ce, busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ptpv2_bus_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .bus2ip_clk     (clk),
    .bus2ip_rst     (rst),
    .req_i          (req),
    .wr_i           (wr),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .lock_i         (lock),
    .ack_o          (ack),
    .rdata_o        (rdata),
    .bus2ip_addr_o  (baddr),
    .bus2ip_data_o  (bdata),
    .bus2ip_rd_ce_o (rd_ce),
    .bus2ip_wr_ce_o (wr_ce),
    .ip2bus_data_i  (ip_data),
    .busy_o         (busy)
  );

  // Core model: returns the addressed word RD_LAT cycles after rd_ce, junk otherwise.
  logic [31:0] core_mem [logic [31:0]];
  int          cd = 0;
  logic [31:0] cd_addr;

  function automatic logic [31:0] core_val(input logic [31:0] a);
    if (core_mem.exists(a)) return core_mem[a];
    return a ^ 32'hC0DE_5A00;
  endfunction

  always @(negedge clk) begin
    if (rd_ce) begin
      cd      = RD_LAT;
      cd_addr = baddr;
      ip_data = $urandom;
    end else if (cd > 0) begin
      cd      = cd - 1;
      ip_data = (cd == 0) ? core_val(cd_addr) : $urandom;
    end else begin
      ip_data = $urandom;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_m(input int unsigned m, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    wr[m]                   = w;
    addr[m*ADDR_W +: ADDR_W] = a;
    wdata[m*32 +: 32]       = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_ce", {rd_ce, wr_ce}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus", {baddr, bdata}, 0);
    rst = 1'b0;
  endtask

  typedef struct {
    int unsigned m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] core;
    int unsigned exp_ack;
    logic [63:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    bit          got = 0;
    int unsigned at = 0;
    int unsigned ce_extra = 0;
    logic [1:0]  ack_seen = '0;
    @(negedge clk);
    core_mem[v.addr] = v.core;
    set_m(v.m, v.wr, v.addr, v.wdata);
    req[v.m] = 1'b1;
    for (int unsigned i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, "_wr_ce"}, wr_ce, v.wr);
        chk({tag, "_rd_ce"}, rd_ce, !v.wr);
        chk({tag, "_addr"}, baddr, v.addr);
        chk({tag, "_data"}, bdata, v.wdata);
        chk({tag, "_busy"}, busy, 1);
      end else if (rd_ce || wr_ce) begin
        ce_extra++;
      end
      if (ack != 0) begin
        got = 1; at = i; ack_seen = ack; req[v.m] = 1'b0;
      end
    end
    req[v.m] = 1'b0;
    chk({tag, "_ack_at"}, at, v.exp_ack);
    chk({tag, "_ack_mask"}, ack_seen, (v.m == 1) ? 2'b10 : 2'b01);
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_ce_once"}, ce_extra, 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_ack"}, ack, 0);
    chk({tag, "_idle_bus"}, {baddr, bdata}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    vec_t        vt [7];
    logic        order [8];
    int unsigned n;
    // reference model state
    bit          m_active;
    int unsigned m_off, m_len;
    logic        m_m, m_wr, m_last, mm;
    logic [31:0] m_addr, m_wd;
    logic [63:0] m_rdata;
    logic [1:0]  exp_ack;

    vt[0] = '{m:0, wr:1, addr:32'h0000_0104, wdata:32'hA5A5_0001, core:32'h0,
              exp_ack:2, exp_rdata:64'h0};
    vt[1] = '{m:1, wr:0, addr:32'h0000_0200, wdata:32'h0, core:32'h1234_5678,
              exp_ack:2 + RD_LAT, exp_rdata:64'h1234_5678_0000_0000};
    vt[2] = '{m:0, wr:0, addr:32'h0000_0108, wdata:32'h1111_2222, core:32'hDEAD_BEEF,
              exp_ack:2 + RD_LAT, exp_rdata:64'h1234_5678_DEAD_BEEF};
    vt[3] = '{m:1, wr:1, addr:32'h0000_020C, wdata:32'h0F0F_0F0F, core:32'h0,
              exp_ack:2, exp_rdata:64'h1234_5678_DEAD_BEEF};
    vt[4] = '{m:1, wr:0, addr:32'h0000_0210, wdata:32'h0, core:32'hCAFE_F00D,
              exp_ack:2 + RD_LAT, exp_rdata:64'hCAFE_F00D_DEAD_BEEF};
    vt[5] = '{m:0, wr:1, addr:32'hFFFF_FFFC, wdata:32'hFFFF_FFFF, core:32'h0,
              exp_ack:2, exp_rdata:64'hCAFE_F00D_DEAD_BEEF};
    vt[6] = '{m:0, wr:0, addr:32'h0000_01FC, wdata:32'h0, core:32'hFFFF_FFFF,
              exp_ack:2 + RD_LAT, exp_rdata:64'hCAFE_F00D_FFFF_FFFF};

    rst = 1'b1; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Fairness from reset with both masters requesting continuously.
    do_reset();
    @(negedge clk);
    set_m(0, 1'b1, 32'h0000_0300, 32'h0000_00A0);
    set_m(1, 1'b1, 32'h0000_0400, 32'h0000_00B0);
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (ack != 0) begin order[n] = ack[1]; n++; end
    end
    req = '0;
    chk("fair_count", n, 6);
    for (int j = 0; j < 6; j++) chk($sformatf("fair_%0d", j), order[j], j % 2);

    // Reset during WAIT aborts the read.
    do_reset();
    @(negedge clk);
    set_m(1, 1'b0, 32'h0000_0220, 32'h0);
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    req = '0;
    chk("abort_ce", {rd_ce, wr_ce}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < RD_LAT + 4; i++) begin
      @(negedge clk);
      if (ack != 0 || rdata != 0) n++;
    end
    chk("abort_no_ack_rdata", n, 0);

`ifdef PTPV2_ARB_LOCK_EN
    // m1 locks for three reads while m0 waits; m0 follows once lock drops.
    do_reset();
    @(negedge clk);
    set_m(1, 1'b0, 32'h0000_0500, 32'h0);
    req[1] = 1'b1; lock[1] = 1'b1;
    @(negedge clk);
    set_m(0, 1'b0, 32'h0000_0600, 32'h0);
    req[0] = 1'b1;
    n = 0;
    begin
      int unsigned n1 = 0;
      bit drop_next = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
        @(negedge clk);
        if (ack != 0) begin
          order[n] = ack[1]; n++;
          if (ack[1]) begin
            n1++;
            if (n1 == 3) begin req[1] = 1'b0; drop_next = 1; end
          end else begin
            req[0] = 1'b0;
          end
        end else if (drop_next) begin
          lock[1] = 1'b0; drop_next = 0;
        end
      end
    end
    req = '0; lock = '0;
    chk("lock_count", n, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("lock_%0d", j), order[j], (j < 3) ? 1 : 0);
`endif

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    m_active = 0; m_off = 0; m_len = 0; m_m = 0; m_wr = 0; m_last = 1'b1;
    m_addr = '0; m_wd = '0; m_rdata = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_ack = (m_active && m_off == m_len) ? (m_m ? 2'b10 : 2'b01) : 2'b00;
      chk("r_busy", busy, m_active);
      chk("r_rd_ce", rd_ce, m_active && m_off == 1 && !m_wr);
      chk("r_wr_ce", wr_ce, m_active && m_off == 1 && m_wr);
      chk("r_ack", ack, exp_ack);
      chk("r_addr", baddr, m_active ? m_addr : 32'h0);
      chk("r_data", bdata, m_active ? m_wd : 32'h0);
      chk("r_rdata", rdata, m_rdata);

      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i]) begin
          if (req[i] && $urandom_range(0, 1) == 1)
            set_m(i, 1'($urandom), 32'h1000 + {$urandom_range(0, 63), 2'b00}, $urandom);
          else
            req[i] = 1'b0;
        end else if (m_active && m_m == 1'(i)) begin
          if (req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_m(i, 1'($urandom), 32'h1000 + {$urandom_range(0, 63), 2'b00}, $urandom);
          req[i] = 1'b1;
        end
      end
`ifdef PTPV2_ARB_LOCK_EN
      lock = '0;
`else
      lock = 2'($urandom);
`endif

      // Advance the model across the coming clock edge.
      if (m_active) begin
        m_off++;
        if (m_off > m_len) m_active = 0;
        else if (m_off == m_len && !m_wr) m_rdata[m_m*32 +: 32] = core_val(m_addr);
      end else if (req != 2'b00) begin
        mm       = (req == 2'b11) ? ~m_last : req[1];
        m_last   = mm;
        m_m      = mm;
        m_wr     = wr[mm];
        m_addr   = addr[mm*ADDR_W +: ADDR_W];
        m_wd     = wdata[mm*32 +: 32];
        m_len    = m_wr ? 2 : RD_LAT + 2;
        m_off    = 1;
        m_active = 1;
      end
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
